// File: rtl/atpg_seq_pkg.sv
// Shared state encoding and default widths for the ATPG vector sequencer.
// Consumed by atpg_vector_sequencer and atpg_resp_checker.
package atpg_seq_pkg;

    localparam int STATE_W   = 3;
    localparam int IN_W_DEF  = 17;
    localparam int OUT_W_DEF = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/atpg_resp_checker.sv
// Response checker: latches the expected word at apply, compares at capture,
// keeps a saturating mismatch count and the index of the first mismatch.
module atpg_resp_checker
    import atpg_seq_pkg::*;
#(
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_apply,
    input  logic              i_capture,
    input  logic [OUT_W-1:0]  i_exp_data,
    input  logic [OUT_W-1:0]  i_cut_out,
    input  logic [ADDR_W-1:0] i_idx,
    output logic              o_miss,
    output logic [ADDR_W:0]   o_fail_count,
    output logic              o_first_fail_vld,
    output logic [ADDR_W-1:0] o_first_fail_idx
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [OUT_W-1:0]  r_exp;
    logic [ADDR_W:0]   r_fail_count;
    logic              r_first_fail_vld;
    logic [ADDR_W-1:0] r_first_fail_idx;
    logic              w_miss;

    assign w_miss           = i_capture && (i_cut_out != r_exp);
    assign o_miss           = w_miss;
    assign o_fail_count     = r_fail_count;
    assign o_first_fail_vld = r_first_fail_vld;
    assign o_first_fail_idx = r_first_fail_idx;

    // Expected-word latch, mismatch counter and first-fail record.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp            <= '0;
            r_fail_count     <= '0;
            r_first_fail_vld <= 1'b0;
            r_first_fail_idx <= '0;
        end else begin
            if (i_apply) begin
                r_exp <= i_exp_data;
            end
            if (i_clear) begin
                r_fail_count     <= '0;
                r_first_fail_vld <= 1'b0;
                r_first_fail_idx <= '0;
            end else if (w_miss) begin
                if (r_fail_count != '1) begin
                    r_fail_count <= r_fail_count + CNT_ONE;
                end
                if (!r_first_fail_vld) begin
                    r_first_fail_vld <= 1'b1;
                    r_first_fail_idx <= i_idx;
                end
            end
        end
    end

endmodule

// File: rtl/atpg_vector_sequencer.sv
// Cycle-exact ATPG vector sequencer: fetch, apply, settle, capture, compare.
// Optional macro HALT_ON_FAIL_EN stops the run at the first mismatching capture.
module atpg_vector_sequencer
    import atpg_seq_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int NUM_VEC    = 50,
    parameter int ADDR_W     = 6,
    parameter int SETTLE_CYC = 1
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [IN_W-1:0]   vec_data,
    input  logic [OUT_W-1:0]  exp_data,
    output logic [IN_W-1:0]   cut_in,
    input  logic [OUT_W-1:0]  cut_out,
    output logic              cap_valid,
    output logic [ADDR_W-1:0] cap_idx,
    output logic [OUT_W-1:0]  cap_data,
    output logic              cap_miss,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   fail_count,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_idx
);

    localparam int                CNT_W       = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VEC - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE     = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [IN_W-1:0]   r_cut_in;
    logic              r_cap_valid;
    logic [ADDR_W-1:0] r_cap_idx;
    logic [OUT_W-1:0]  r_cap_data;
    logic              r_cap_miss;
    logic              r_busy;
    logic              r_done;

    logic w_start;
    logic w_apply;
    logic w_capture;
    logic w_miss;
    logic w_last;
    logic w_finish;

    assign w_apply   = (r_state == ST_APPLY);
    assign w_capture = (r_state == ST_CAPTURE);
    assign w_last    = (r_idx == LAST_IDX);
`ifdef HALT_ON_FAIL_EN
    assign w_finish  = w_last || w_miss;
`else
    assign w_finish  = w_last;
`endif

    // State register.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is honoured only from IDLE or DONE.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next  = ST_FETCH;
                    w_start = 1'b1;
                end else begin
                    w_next  = r_state;
                end
            end
            ST_FETCH:   w_next = ST_APPLY;
            ST_APPLY:   w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next = ST_CAPTURE;
                end else begin
                    w_next = ST_SETTLE;
                end
            end
            ST_CAPTURE: begin
                if (w_finish) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Datapath: vector index, settle countdown, CUT drive and capture outputs.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_cut_in    <= '0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_data  <= '0;
            r_cap_miss  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cap_valid <= w_capture;
            r_cap_miss  <= w_miss;
            if (w_start) begin
                r_idx  <= '0;
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end
            if (w_apply) begin
                r_cut_in <= vec_data;
                r_cnt    <= SETTLE_LOAD;
            end
            if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_capture) begin
                r_cap_data <= cut_out;
                r_cap_idx  <= r_idx;
                if (w_finish) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end
        end
    end

    atpg_resp_checker #(
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_checker (
        .i_clk            (CK),
        .i_rst            (RST),
        .i_clear          (w_start),
        .i_apply          (w_apply),
        .i_capture        (w_capture),
        .i_exp_data       (exp_data),
        .i_cut_out        (cut_out),
        .i_idx            (r_idx),
        .o_miss           (w_miss),
        .o_fail_count     (fail_count),
        .o_first_fail_vld (first_fail_vld),
        .o_first_fail_idx (first_fail_idx)
    );

    assign vec_addr  = r_idx;
    assign cut_in    = r_cut_in;
    assign cap_valid = r_cap_valid;
    assign cap_idx   = r_cap_idx;
    assign cap_data  = r_cap_data;
    assign cap_miss  = r_cap_miss;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_atpg_vector_sequencer.sv
// Directed bench for atpg_vector_sequencer: three instances (50 vectors/settle 1,
// 8 vectors/settle 4 with a delayed CUT, single vector); honours HALT_ON_FAIL_EN.
module tb_atpg_vector_sequencer;

    logic CK = 1'b0;
    logic RST;
    always #5 CK = ~CK;

    logic [16:0] vec_mem  [64];
    logic [4:0]  exp_mem0 [64];
    logic [4:0]  exp_good [64];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [4:0] cut_f(input logic [16:0] v);
        return v[4:0] ^ v[9:5] ^ v[14:10] ^ {3'b000, v[16:15]} ^ {v[0], v[16], v[8], v[3], v[11]};
    endfunction

    // ---------------- instance 0: NUM_VEC=50, SETTLE_CYC=1 ----------------
    logic        start0;
    logic [5:0]  vec_addr0, cap_idx0, ffi0;
    logic [16:0] vec_data0, cut_in0;
    logic [4:0]  exp_data0, cut_out0, cap_data0;
    logic        cap_valid0, cap_miss0, busy0, done0, ffv0;
    logic [6:0]  fail_count0;

    always @(posedge CK) begin
        vec_data0 <= vec_mem[vec_addr0];
        exp_data0 <= exp_mem0[vec_addr0];
    end
    assign cut_out0 = cut_f(cut_in0);

    atpg_vector_sequencer #(.IN_W(17), .OUT_W(5), .NUM_VEC(50), .ADDR_W(6), .SETTLE_CYC(1)) dut0 (
        .CK(CK), .RST(RST), .start(start0), .vec_addr(vec_addr0), .vec_data(vec_data0),
        .exp_data(exp_data0), .cut_in(cut_in0), .cut_out(cut_out0), .cap_valid(cap_valid0),
        .cap_idx(cap_idx0), .cap_data(cap_data0), .cap_miss(cap_miss0), .busy(busy0),
        .done(done0), .fail_count(fail_count0), .first_fail_vld(ffv0), .first_fail_idx(ffi0)
    );

    // ---------------- instance 4: NUM_VEC=8, SETTLE_CYC=4, CUT delay 3 ----------------
    logic        start4;
    logic [5:0]  vec_addr4, cap_idx4, ffi4;
    logic [16:0] vec_data4, cut_in4;
    logic [4:0]  exp_data4, cap_data4;
    logic [4:0]  cut_out4 = 5'd0;
    logic [4:0]  dly1 = 5'd0;
    logic [4:0]  dly2 = 5'd0;
    logic        cap_valid4, cap_miss4, busy4, done4, ffv4;
    logic [6:0]  fail_count4;

    always @(posedge CK) begin
        vec_data4 <= vec_mem[vec_addr4];
        exp_data4 <= exp_good[vec_addr4];
        dly1      <= cut_f(cut_in4);
        dly2      <= dly1;
        cut_out4  <= dly2;
    end

    atpg_vector_sequencer #(.IN_W(17), .OUT_W(5), .NUM_VEC(8), .ADDR_W(6), .SETTLE_CYC(4)) dut4 (
        .CK(CK), .RST(RST), .start(start4), .vec_addr(vec_addr4), .vec_data(vec_data4),
        .exp_data(exp_data4), .cut_in(cut_in4), .cut_out(cut_out4), .cap_valid(cap_valid4),
        .cap_idx(cap_idx4), .cap_data(cap_data4), .cap_miss(cap_miss4), .busy(busy4),
        .done(done4), .fail_count(fail_count4), .first_fail_vld(ffv4), .first_fail_idx(ffi4)
    );

    // ---------------- instance 1: NUM_VEC=1, SETTLE_CYC=1 ----------------
    logic        start1;
    logic [5:0]  vec_addr1, cap_idx1, ffi1;
    logic [16:0] vec_data1, cut_in1;
    logic [4:0]  exp_data1, cut_out1, cap_data1;
    logic        cap_valid1, cap_miss1, busy1, done1, ffv1;
    logic [6:0]  fail_count1;

    always @(posedge CK) begin
        vec_data1 <= vec_mem[vec_addr1];
        exp_data1 <= exp_good[vec_addr1];
    end
    assign cut_out1 = cut_f(cut_in1);

    atpg_vector_sequencer #(.IN_W(17), .OUT_W(5), .NUM_VEC(1), .ADDR_W(6), .SETTLE_CYC(1)) dut1 (
        .CK(CK), .RST(RST), .start(start1), .vec_addr(vec_addr1), .vec_data(vec_data1),
        .exp_data(exp_data1), .cut_in(cut_in1), .cut_out(cut_out1), .cap_valid(cap_valid1),
        .cap_idx(cap_idx1), .cap_data(cap_data1), .cap_miss(cap_miss1), .busy(busy1),
        .done(done1), .fail_count(fail_count1), .first_fail_vld(ffv1), .first_fail_idx(ffi1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs0();
        return {12'd0, vec_addr0, cut_in0, cap_valid0, cap_idx0, cap_data0, cap_miss0,
                busy0, done0, fail_count0, ffv0, ffi0};
    endfunction

    // Steps instance 0 until done (bounded), checking every capture on the way.
    task automatic watch_main(input int max_cyc, input logic [63:0] miss_mask,
                              output int cyc, output int ncap);
        cyc  = 0;
        ncap = 0;
        while (cyc < max_cyc) begin
            @(posedge CK); #1;
            cyc++;
            if (cap_valid0) begin
                chk("cap_idx", 64'(cap_idx0), 64'(ncap));
                chk("cap_miss", 64'(cap_miss0), 64'(miss_mask[ncap]));
                chk("cap_data", 64'(cap_data0), 64'(cut_f(vec_mem[ncap])));
                ncap++;
            end
            if (done0) break;
        end
        chk("main_done_seen", 64'(done0), 64'd1);
    endtask

    initial begin
        int cyc;
        int ncap;
        int last;

        for (int i = 0; i < 64; i++) begin
            vec_mem[i]  = 17'(i * 32'h0000_2C4B + 32'h0001_05A3);
            exp_good[i] = cut_f(vec_mem[i]);
            exp_mem0[i] = exp_good[i];
        end
        RST    = 1'b1;
        start0 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        chk("reset_outs0", outs0(), 64'd0);
        chk("reset_outs4", {busy4, done4, cap_valid4, cut_in4, vec_addr4}, 64'd0);
        RST = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        chk("idle_busy", 64'(busy0), 64'd0);

`ifndef HALT_ON_FAIL_EN
        // Corrupted expected words at 7 and 31.
        exp_mem0[7]  = exp_good[7] ^ 5'h01;
        exp_mem0[31] = exp_good[31] ^ 5'h10;
        start0 = 1'b1;
        @(posedge CK); #1;
        start0 = 1'b0;
        chk("start_busy", 64'(busy0), 64'd1);
        chk("start_addr", 64'(vec_addr0), 64'd0);
        watch_main(400, (64'd1 << 7) | (64'd1 << 31), cyc, ncap);
        chk("bad_cycles", 64'(cyc), 64'd200);
        chk("bad_ncap", 64'(ncap), 64'd50);
        chk("bad_fail_count", 64'(fail_count0), 64'd2);
        chk("bad_ffv", 64'(ffv0), 64'd1);
        chk("bad_ffi", 64'(ffi0), 64'd7);
        repeat (5) @(posedge CK);
        #1;
        chk("hold_done", 64'(done0), 64'd1);
        chk("hold_fail_count", 64'(fail_count0), 64'd2);
        chk("hold_ffi", 64'(ffi0), 64'd7);
        chk("hold_cut_in", 64'(cut_in0), 64'(vec_mem[49]));
        exp_mem0[7]  = exp_good[7];
        exp_mem0[31] = exp_good[31];
`else
        // Halting run: bad expected word at index 3.
        exp_mem0[3] = exp_good[3] ^ 5'h04;
        start0 = 1'b1;
        @(posedge CK); #1;
        start0 = 1'b0;
        chk("start_busy", 64'(busy0), 64'd1);
        watch_main(400, 64'd1 << 3, cyc, ncap);
        chk("halt_cycles", 64'(cyc), 64'd16);
        chk("halt_ncap", 64'(ncap), 64'd4);
        chk("halt_fail_count", 64'(fail_count0), 64'd1);
        chk("halt_ffi", 64'(ffi0), 64'd3);
        chk("halt_cap_idx", 64'(cap_idx0), 64'd3);
        chk("halt_cut_in", 64'(cut_in0), 64'(vec_mem[3]));
        chk("halt_busy", 64'(busy0), 64'd0);
        exp_mem0[3] = exp_good[3];
`endif

        // Clean run with start held high throughout.
        start0 = 1'b1;
        @(posedge CK); #1;
        chk("restart_fail_clr", 64'(fail_count0), 64'd0);
        chk("restart_ffv_clr", 64'(ffv0), 64'd0);
        chk("restart_done_clr", 64'(done0), 64'd0);
        watch_main(400, 64'd0, cyc, ncap);
        chk("clean_cycles", 64'(cyc), 64'd200);
        chk("clean_ncap", 64'(ncap), 64'd50);
        chk("clean_fail_count", 64'(fail_count0), 64'd0);
        chk("clean_ffv", 64'(ffv0), 64'd0);
        chk("clean_busy", 64'(busy0), 64'd0);
        @(posedge CK); #1;
        chk("auto_restart_busy", 64'(busy0), 64'd1);
        chk("auto_restart_done", 64'(done0), 64'd0);
        chk("auto_restart_addr", 64'(vec_addr0), 64'd0);
        start0 = 1'b0;

        // Abort with RST while vector 20 is settling.
        cyc = 0;
        while (cyc < 300) begin
            @(posedge CK); #1;
            cyc++;
            if (cap_valid0 && (cap_idx0 == 6'd19)) break;
        end
        chk("saw_cap19", 64'(cap_idx0), 64'd19);
        repeat (2) @(posedge CK);
        #1;
        chk("pre_rst_addr", 64'(vec_addr0), 64'd20);
        chk("pre_rst_cut_in", 64'(cut_in0), 64'(vec_mem[20]));
        RST = 1'b1;
        @(posedge CK); #1;
        chk("midrun_rst_outs", outs0(), 64'd0);
        RST = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        chk("post_rst_idle", {busy0, done0, cap_valid0}, 64'd0);
        start0 = 1'b1;
        @(posedge CK); #1;
        start0 = 1'b0;
        chk("rerun_addr", 64'(vec_addr0), 64'd0);
        watch_main(400, 64'd0, cyc, ncap);
        chk("rerun_cycles", 64'(cyc), 64'd200);
        chk("rerun_ncap", 64'(ncap), 64'd50);

        // Instance 4: settle 4, CUT with 3-cycle output delay.
        start4 = 1'b1;
        @(posedge CK); #1;
        start4 = 1'b0;
        cyc  = 0;
        ncap = 0;
        last = 0;
        while (cyc < 200) begin
            @(posedge CK); #1;
            cyc++;
            if (cap_valid4) begin
                if (ncap > 0) chk("s4_spacing", 64'(cyc - last), 64'd7);
                chk("s4_miss", 64'(cap_miss4), 64'd0);
                chk("s4_idx", 64'(cap_idx4), 64'(ncap));
                last = cyc;
                ncap++;
            end
            if (done4) break;
        end
        chk("s4_cycles", 64'(cyc), 64'd56);
        chk("s4_ncap", 64'(ncap), 64'd8);
        chk("s4_fail_count", 64'(fail_count4), 64'd0);

        // Instance 1: single vector.
        start1 = 1'b1;
        @(posedge CK); #1;
        start1 = 1'b0;
        cyc  = 0;
        ncap = 0;
        while (cyc < 50) begin
            @(posedge CK); #1;
            cyc++;
            if (cap_valid1) begin
                chk("nv1_idx", 64'(cap_idx1), 64'd0);
                chk("nv1_data", 64'(cap_data1), 64'(cut_f(vec_mem[0])));
                ncap++;
            end
            if (done1) break;
        end
        chk("nv1_cycles", 64'(cyc), 64'd4);
        repeat (3) @(posedge CK);
        #1;
        chk("nv1_ncap", 64'(ncap), 64'd1);
        chk("nv1_no_extra_cap", 64'(cap_valid1), 64'd0);
        chk("nv1_done_hold", 64'(done1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/atpg_vector_sequencer.md
Name: atpg_vector_sequencer

Overview:
Self-contained test controller for an ISCAS89 circuit-under-test (CUT).
- Walks a stored test-vector memory and drives each vector onto the CUT inputs.
- Waits a programmable settle time, then captures the CUT outputs and compares them with the expected response.
- Accumulates a pass/fail summary.
- Replaces free-running testbench loops with a synthesizable, cycle-exact sequencer in front of any sNNNN netlist.

Parameters:
IN_W, 17, CUT primary-input width (vector width)
OUT_W, 5, CUT primary-output width
NUM_VEC, 50, number of vectors applied per run (1..2^ADDR_W)
ADDR_W, 6, vector/expected-memory address width
SETTLE_CYC, 1, cycles between applying a vector and capturing outputs (>=1)

Ports:
CK  in  1  clock, rising edge
RST  in  1  reset (see Behaviour)
start  in  1  begin a run; sampled only in IDLE or DONE
vec_addr  out  ADDR_W  address to vector and expected memories
vec_data  in  IN_W  stimulus word, valid 1 cycle after vec_addr (synchronous ROM)
exp_data  in  OUT_W  expected response, same timing as vec_data
cut_in  out  IN_W  registered drive to CUT inputs
cut_out  in  OUT_W  CUT outputs
cap_valid  out  1  one-cycle pulse, capture performed
cap_idx  out  ADDR_W  index of captured vector
cap_data  out  OUT_W  captured CUT response
cap_miss  out  1  capture mismatched (qualified by cap_valid)
busy  out  1  run in progress
done  out  1  run complete (level)
fail_count  out  ADDR_W+1  mismatching vectors this run
first_fail_vld  out  1  at least one mismatch seen
first_fail_idx  out  ADDR_W  index of first mismatch

Behaviour:
- One clock CK; RST is synchronous and active-high.
- Reset values: every output is 0, state is IDLE, settle counter is 0.
- RST asserted mid-run aborts the run immediately; results are not retained.
- States: IDLE, FETCH, APPLY, SETTLE, CAPTURE, DONE.
- IDLE / DONE:
  - start=1 clears fail_count, first_fail_vld, first_fail_idx and done.
  - It sets idx=0, vec_addr=0, busy=1 and moves to FETCH.
  - start in any other state is ignored.
- FETCH: vec_addr=idx is presented; next state is APPLY.
- APPLY:
  - cut_in<=vec_data; the expected word is latched from exp_data.
  - The settle counter loads SETTLE_CYC-1; next state is SETTLE.
- SETTLE: counts down; moves to CAPTURE in the cycle after the counter reads 0, giving exactly SETTLE_CYC cycles.
- CAPTURE:
  - cap_data<=cut_out, cap_idx<=idx, cap_valid=1 for one cycle.
  - cap_miss = (cut_out != expected).
  - On a mismatch, fail_count increments (saturating at all-ones).
  - On the first mismatch of the run, first_fail_idx<=idx and first_fail_vld<=1.
  - If idx==NUM_VEC-1: next state DONE, busy<=0, done<=1.
  - Otherwise idx<=idx+1 and next state FETCH.
- Per-vector cost is SETTLE_CYC+3 cycles.
  - Full run: NUM_VEC*(SETTLE_CYC+3) cycles from the start sample to done rising.
- cut_in holds the last applied vector through DONE/IDLE until the next APPLY; it is cleared only by reset.
- Results (fail_count, first_fail_*) stay stable in DONE until the next start.
- NUM_VEC=1 is legal: a single FETCH→CAPTURE pass, then DONE.
- idx never wraps; the final-index compare terminates the run before overflow.

Optional Feature:
HALT_ON_FAIL_EN
- Defined:
  - A mismatching CAPTURE moves straight to DONE (done=1, busy=0), so fail_count=1.
  - cap_idx and first_fail_idx hold the failing index.
  - cut_in keeps the failing vector for debug.
- Undefined: all NUM_VEC vectors are always applied, regardless of mismatches.

Decomposition:
- Package atpg_seq_pkg contains:
  - state enum (IDLE, FETCH, APPLY, SETTLE, CAPTURE, DONE);
  - state-width constant;
  - default width constants IN_W_DEF=17, OUT_W_DEF=5.
- One natural sub-module, atpg_resp_checker, holds the expected-word latch, compare, saturating fail counter and first-fail capture.
  - It is driven by apply/capture/clear strobes from the FSM.

Test Plan:
- Clean run with NUM_VEC=50, SETTLE_CYC=1 and the CUT model matching expected data → done rises 200 cycles after start, fail_count=0, first_fail_vld=0, 50 cap_valid pulses with cap_idx 0..49.
- Expected memory corrupted at indices 7 and 31 → fail_count=2, first_fail_idx=7, cap_miss high only on captures 7 and 31.
- SETTLE_CYC=4 with a CUT model whose outputs update 3 cycles after its input changes → no mismatches; cap_valid spacing is exactly 7 cycles.
- RST pulsed at vector 20 during SETTLE → next cycle all outputs 0 and state IDLE; a subsequent start runs from vec_addr=0.
- start held high throughout a run → ignored while busy; in DONE it restarts with counters cleared; with HALT_ON_FAIL_EN and a bad vector at index 3 → done after 4 captures, fail_count=1, cut_in equals vector 3.
- NUM_VEC=1 → exactly one cap_valid pulse, done after SETTLE_CYC+3 cycles.
